// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive state encodings, oversampling constants and helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int OSM_FULL_16 = 16;
    localparam int OSM_FULL_13 = 13;
    localparam int OSM_HALF_16 = 8;
    localparam int OSM_HALF_13 = 6;

    localparam logic [1:0] WLS_5 = 2'd0;
    localparam logic [1:0] WLS_6 = 2'd1;
    localparam logic [1:0] WLS_7 = 2'd2;
    localparam logic [1:0] WLS_8 = 2'd3;

    // Last cycle index of a full bit period
    function automatic logic [3:0] full_m1(input logic osm);
        return osm ? 4'(OSM_FULL_13 - 1) : 4'(OSM_FULL_16 - 1);
    endfunction

    // Last cycle index of a half bit period (start-bit centre)
    function automatic logic [3:0] half_m1(input logic osm);
        return osm ? 4'(OSM_HALF_13 - 1) : 4'(OSM_HALF_16 - 1);
    endfunction

    // Mask of valid data bits for a word-length select
    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        logic [7:0] m;
        m = 8'hFF;
        case (wls)
            WLS_5: m = 8'h1F;
            WLS_6: m = 8'h3F;
            WLS_7: m = 8'h7F;
            WLS_8: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_rx_deshift_if.sv
// uart_rx_deshift_if: receive line, frame configuration and character/flag outputs
interface uart_rx_deshift_if;
    logic       enable_in;
    logic       serial_in;
    logic       osm_sel_in;
    logic [1:0] wls_in;
    logic       pen_in;
    logic       eps_in;
    logic       sp_in;
    logic [7:0] rbr_out;
    logic       rx_valid_out;
    logic       pe_out;
    logic       fe_out;
    logic       bi_out;
    logic       busy_out;

    modport master (
        output enable_in, serial_in, osm_sel_in, wls_in, pen_in, eps_in, sp_in,
        input  rbr_out, rx_valid_out, pe_out, fe_out, bi_out, busy_out
    );

    modport slave (
        input  enable_in, serial_in, osm_sel_in, wls_in, pen_in, eps_in, sp_in,
        output rbr_out, rx_valid_out, pe_out, fe_out, bi_out, busy_out
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for an asynchronous idle-high line plus falling-edge detect
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rx_s,
    output logic o_fall_edge
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the line through the synchronizer and keep the previous synchronized value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rx_s      = r_sync[SYNC_STAGES-1];
    assign o_fall_edge = r_prev & ~r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_deshift.sv
// uart_rx_deshift: UART receive deserializer with start validation, parity and framing checks
module uart_rx_deshift
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              bclk_in,
    input  logic              rstn_in,
    uart_rx_deshift_if.slave  bus
);
    rx_state_t  r_state, w_state_nxt;
    logic [3:0] r_cyc, w_cyc_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_pe_flag, w_pe_flag_nxt;
    logic       r_par_bit, w_par_bit_nxt;
    logic       r_osm, w_osm_nxt;
    logic [1:0] r_wls, w_wls_nxt;
    logic       r_pen, w_pen_nxt;
    logic       r_eps, w_eps_nxt;
    logic       r_sp, w_sp_nxt;
    logic [7:0] r_rbr, w_rbr_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_pe, w_pe_nxt;
    logic       r_fe, w_fe_nxt;
    logic       r_bi, w_bi_nxt;
    logic       w_rx, w_fall, w_tick, w_par_exp;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk       (bclk_in),
        .i_rst_n     (rstn_in),
        .i_d         (bus.serial_in),
        .o_rx_s      (w_rx),
        .o_fall_edge (w_fall)
    );

    assign w_tick    = (r_cyc == full_m1(r_osm));
    assign w_par_exp = r_sp ? ~r_eps : (r_eps ? ^r_shift : ~^r_shift);

    // Next-state and datapath decode for the receive frame sequence
    always_comb begin
        w_state_nxt   = r_state;
        w_cyc_nxt     = r_cyc;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_pe_flag_nxt = r_pe_flag;
        w_par_bit_nxt = r_par_bit;
        w_osm_nxt     = r_osm;
        w_wls_nxt     = r_wls;
        w_pen_nxt     = r_pen;
        w_eps_nxt     = r_eps;
        w_sp_nxt      = r_sp;
        w_rbr_nxt     = r_rbr;
        w_valid_nxt   = 1'b0;
        w_pe_nxt      = r_pe;
        w_fe_nxt      = r_fe;
        w_bi_nxt      = r_bi;
        if (!bus.enable_in) begin
            w_state_nxt = ST_IDLE;
            w_cyc_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = ST_START;
                        w_cyc_nxt   = '0;
                    end
                end
                ST_START: begin
                    w_cyc_nxt = r_cyc + 4'd1;
                    if (r_cyc == half_m1(bus.osm_sel_in)) begin
                        if (w_rx) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt   = ST_DATA;
                            w_cyc_nxt     = '0;
                            w_bit_nxt     = '0;
                            w_shift_nxt   = '0;
                            w_pe_flag_nxt = 1'b0;
                            w_par_bit_nxt = 1'b0;
                            w_osm_nxt     = bus.osm_sel_in;
                            w_wls_nxt     = bus.wls_in;
                            w_pen_nxt     = bus.pen_in;
                            w_eps_nxt     = bus.eps_in;
                            w_sp_nxt      = bus.sp_in;
                        end
                    end
                end
                ST_DATA: begin
                    w_cyc_nxt = r_cyc + 4'd1;
                    if (w_tick) begin
                        w_cyc_nxt            = '0;
                        w_shift_nxt[r_bit]   = w_rx;
                        w_bit_nxt            = r_bit + 3'd1;
                        if (r_bit == {1'b0, r_wls} + 3'd4)
                            w_state_nxt = r_pen ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    w_cyc_nxt = r_cyc + 4'd1;
                    if (w_tick) begin
                        w_cyc_nxt     = '0;
                        w_par_bit_nxt = w_rx;
                        w_pe_flag_nxt = w_rx != w_par_exp;
                        w_state_nxt   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    w_cyc_nxt = r_cyc + 4'd1;
                    if (w_tick) begin
                        w_cyc_nxt   = '0;
                        w_rbr_nxt   = r_shift & wls_mask(r_wls);
                        w_fe_nxt    = ~w_rx;
                        w_pe_nxt    = r_pe_flag;
                        w_bi_nxt    = ((r_shift & wls_mask(r_wls)) == 8'h00) && (!r_pen || !r_par_bit) && !w_rx;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counters, frame config and result registers
    always_ff @(posedge bclk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            r_state   <= ST_IDLE;
            r_cyc     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_pe_flag <= 1'b0;
            r_par_bit <= 1'b0;
            r_osm     <= 1'b0;
            r_wls     <= '0;
            r_pen     <= 1'b0;
            r_eps     <= 1'b0;
            r_sp      <= 1'b0;
            r_rbr     <= '0;
            r_valid   <= 1'b0;
            r_pe      <= 1'b0;
            r_fe      <= 1'b0;
            r_bi      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_pe_flag <= w_pe_flag_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_osm     <= w_osm_nxt;
            r_wls     <= w_wls_nxt;
            r_pen     <= w_pen_nxt;
            r_eps     <= w_eps_nxt;
            r_sp      <= w_sp_nxt;
            r_rbr     <= w_rbr_nxt;
            r_valid   <= w_valid_nxt;
            r_pe      <= w_pe_nxt;
            r_fe      <= w_fe_nxt;
            r_bi      <= w_bi_nxt;
        end
    end

    assign bus.rbr_out      = r_rbr;
    assign bus.rx_valid_out = r_valid;
    assign bus.pe_out       = r_pe;
    assign bus.fe_out       = r_fe;
    assign bus.bi_out       = r_bi;
    assign bus.busy_out     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_deshift.sv
// tb_uart_rx_deshift: directed frame table plus corner-case sequences for the UART receiver
module tb_uart_rx_deshift;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;

    uart_rx_deshift_if bus ();

    uart_rx_deshift #(.SYNC_STAGES(2)) dut (
        .bclk_in (clk),
        .rstn_in (rstn),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    // Count receive pulses away from the active edge
    always @(negedge clk) if (bus.rx_valid_out === 1'b1) pulses <= pulses + 1;

    typedef struct {
        logic       osm;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic       sp;
        logic [7:0] data;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_rbr;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_bi;
    } frame_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.serial_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input frame_t f);
        bus.osm_sel_in = f.osm;
        bus.wls_in     = f.wls;
        bus.pen_in     = f.pen;
        bus.eps_in     = f.eps;
        bus.sp_in      = f.sp;
    endtask

    task automatic send_frame(input frame_t f);
        int full;
        full = f.osm ? 13 : 16;
        set_cfg(f);
        drive(1'b0, full);
        for (int i = 0; i < 5 + int'(f.wls); i++) drive(f.data[i], full);
        if (f.pen) drive(f.par_bit, full);
        drive(f.stop_bit, full);
        bus.serial_in = 1'b1;
    endtask

    frame_t vec [10];
    frame_t cfg8;
    int     base;
    int     full;

    initial begin
        //           osm   wls   pen   eps   sp    data   par   stop  rbr    pe    fe    bi
        vec[0] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
        vec[2] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vec[3] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
        vec[4] = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vec[5] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vec[6] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'hEA, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
        vec[7] = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vec[8] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vec[9] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0};
        cfg8   = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        bus.serial_in = 1'b1;
        bus.enable_in = 1'b1;
        set_cfg(cfg8);
        repeat (3) @(negedge clk);
        check("reset_rbr", bus.rbr_out, 8'h00);
        check("reset_valid", {7'b0, bus.rx_valid_out}, 8'h00);
        check("reset_flags", {5'b0, bus.pe_out, bus.fe_out, bus.bi_out}, 8'h00);
        check("reset_busy", {7'b0, bus.busy_out}, 8'h00);
        rstn = 1'b1;
        repeat (20) @(negedge clk);

        // Break: line low for 12 bit times, then high
        base = pulses;
        drive(1'b0, 12 * 16);
        drive(1'b1, 16);
        check("break_pulses", 8'(pulses - base), 8'd1);
        check("break_rbr", bus.rbr_out, 8'h00);
        check("break_bi", {7'b0, bus.bi_out}, 8'h01);
        check("break_fe", {7'b0, bus.fe_out}, 8'h01);
        drive(1'b1, 3 * 16);
        check("break_no_second", 8'(pulses - base), 8'd1);
        check("break_busy", {7'b0, bus.busy_out}, 8'h00);

        // Glitch shorter than half a bit: false start
        base = pulses;
        drive(1'b0, 4);
        check("glitch_busy_start", {7'b0, bus.busy_out}, 8'h01);
        drive(1'b1, 40);
        check("glitch_pulses", 8'(pulses - base), 8'd0);
        check("glitch_busy", {7'b0, bus.busy_out}, 8'h00);
        check("glitch_flags_held", {5'b0, bus.pe_out, bus.fe_out, bus.bi_out}, 8'h03);

        // Frame table
        for (int v = 0; v < 10; v++) begin
            full = vec[v].osm ? 13 : 16;
            base = pulses;
            send_frame(vec[v]);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_busy", v), {7'b0, bus.busy_out}, 8'h00);
            repeat (2 * full) @(negedge clk);
            check($sformatf("v%0d_pulses", v), 8'(pulses - base), 8'd1);
            check($sformatf("v%0d_rbr", v), bus.rbr_out, vec[v].exp_rbr);
            check($sformatf("v%0d_pe", v), {7'b0, bus.pe_out}, {7'b0, vec[v].exp_pe});
            check($sformatf("v%0d_fe", v), {7'b0, bus.fe_out}, {7'b0, vec[v].exp_fe});
            check($sformatf("v%0d_bi", v), {7'b0, bus.bi_out}, {7'b0, vec[v].exp_bi});
        end

        // Enable dropped during data bit 3
        set_cfg(cfg8);
        base = pulses;
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b1, 8);
        bus.enable_in = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy", {7'b0, bus.busy_out}, 8'h00);
        drive(1'b1, 8);
        for (int i = 0; i < 4; i++) drive(1'b0, 16);
        drive(1'b1, 48);
        check("en_pulses", 8'(pulses - base), 8'd0);
        check("en_rbr_held", bus.rbr_out, 8'h13);
        check("en_pe_held", {7'b0, bus.pe_out}, 8'h01);
        bus.enable_in = 1'b1;
        drive(1'b1, 32);
        check("en_busy_after", {7'b0, bus.busy_out}, 8'h00);

        // Reset asserted mid-frame
        base = pulses;
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b1, 8);
        check("rst_busy_before", {7'b0, bus.busy_out}, 8'h01);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_busy", {7'b0, bus.busy_out}, 8'h00);
        check("rst_rbr", bus.rbr_out, 8'h00);
        check("rst_flags", {4'b0, bus.rx_valid_out, bus.pe_out, bus.fe_out, bus.bi_out}, 8'h00);
        drive(1'b1, 8);
        rstn = 1'b1;
        drive(1'b1, 64);
        check("rst_pulses", 8'(pulses - base), 8'd0);
        check("rst_busy_after", {7'b0, bus.busy_out}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
